mouse_packet_ctrl: RTL and testbench
====================================

// Module: mouse_packet_ctrl
// PURPOSE
//  Packet sequencer behind the serial mouse word reader. Takes 11-bit frames on word/word_ready,
//  checks framing and odd parity, aligns on the PS/2 sync bit, and assembles 3-frame packets.
//  Decodes each packet into buttons, 9-bit signed dx/dy and overflow flags, and holds it on a
//  valid/ready interface. Drops stalled partial packets and pulses rdr_clr to resync the reader.
// PARAMETERS
//  TIMEOUT_CYCLES  2000  ck cycles allowed between frames inside a packet (>=2)
//  CHECK_PARITY    1     1: reject frames with even parity; 0: ignore parity bit
//  ERR_W           8     width of saturating error counter
// PORTS
//  ck          in   1      system clock, rising edge
//  reset       in   1      asynchronous, active-low reset
//  word_ready  in   1      reader frame-available level; frame taken on its 0->1 edge
//  word        in   11     [10]=start [9:2]=D0..D7 (word[9]=D0) [1]=parity [0]=stop
//  pkt_ready   in   1      consumer accepts packet when high with pkt_valid
//  pkt_valid   out  1      packet outputs valid; held until accepted
//  buttons     out  3      {M,R,L} = byte0[2:0]
//  dx          out  9      {byte0[4], byte1}, two's complement
//  dy          out  9      {byte0[5], byte2}, two's complement
//  ovf_x       out  1      byte0[6]
//  ovf_y       out  1      byte0[7]
//  raw_pkt     out  33     {frame0, frame1, frame2} as received
//  frame_err   out  1      1-cycle pulse per rejected/dropped frame or timeout
//  rdr_clr     out  1      1-cycle pulse on timeout, to clear the reader
//  err_count   out  ERR_W  saturating count of frame_err pulses
//  busy        out  1      high in S_B1, S_B2
// BEHAVIOUR
//  Reset (reset=0): all outputs 0, state S_B0, timeout counter 0, edge-detect register 0.
//  Frame accept: an edge detected on cycle N is processed on cycle N, using word as sampled on N.
//  Frame is valid iff start=0, stop=1 and (CHECK_PARITY=0 or ^{D7..D0,parity}=1).
//  FSM:
//   S_B0: valid frame with D3=1 -> store byte0, go S_B1. Invalid or D3=0 -> drop, frame_err.
//   S_B1: valid frame -> byte1, go S_B2. Invalid -> drop partial, frame_err, go S_B0.
//   S_B2: valid frame -> byte2, load outputs, pkt_valid=1 next cycle, go S_HOLD.
//         Invalid -> as in S_B1.
//   S_HOLD: pkt_valid=1, outputs stable. pkt_ready=1 -> pkt_valid=0 next cycle, go S_B0.
//         A frame edge while in S_HOLD without pkt_ready -> dropped, frame_err (overrun).
//         Edge and pkt_ready in the same cycle -> packet retired, and frame handled as S_B0 input.
//  Latency: third frame edge on cycle N -> pkt_valid=1 on N+1.
//  Timeout: counter clears on each accepted frame and counts in S_B1/S_B2. Reaching
//   TIMEOUT_CYCLES-1 with no frame -> drop partial, frame_err + rdr_clr pulse, go S_B0.
//   A frame on the expiry cycle wins; no timeout.
//  err_count increments once per frame_err pulse and saturates at 2^ERR_W-1; it never wraps.
//  Decoded outputs update only on entry to S_HOLD. They hold their last values while pkt_valid=0.
//  reset asserted mid-packet or in S_HOLD: immediate return to reset state, packet lost.
// TESTING
//  1 Frames for 0x29,0x05,0xFE (odd parity), pkt_ready=1 -> one pkt_valid pulse;
//    buttons=3'b001, dx=9'h005, dy=9'h1FE (-2), ovf_x=ovf_y=0, err_count=0.
//  2 First frame 0x05 (D3=0) followed by a valid 3-byte packet -> 0x05 dropped, frame_err x1;
//    packet decoded from the next three frames, err_count=1.
//  3 Frame with parity flipped in byte1 position -> frame_err, FSM back to S_B0;
//    next valid 3-frame packet decodes correctly. CHECK_PARITY=0 -> the same frame is accepted.
//  4 Two frames, then silence for TIMEOUT_CYCLES -> rdr_clr and frame_err pulse once each,
//    busy=0, no pkt_valid.
//  5 pkt_ready=0, packet held, extra frame arrives -> outputs unchanged, frame_err;
//    raise pkt_ready on the same cycle as the next edge -> that frame starts the new packet.
//  6 Force 300 bad frames with ERR_W=8 -> err_count stops at 255. Assert reset mid-S_B2 ->
//    all outputs 0, FSM in S_B0.

Source files
------------

// File: rtl/mouse_packet_ctrl.sv
// Packet sequencer for a PS/2-style mouse: validates 11-bit frames, aligns on the sync bit,
// assembles 3-byte packets, decodes them and holds the result on a valid/ready interface.
module mouse_packet_ctrl #(
   parameter int TIMEOUT_CYCLES = 2000,
   parameter bit CHECK_PARITY   = 1'b1,
   parameter int ERR_W          = 8
) (
   input  logic             ck,
   input  logic             reset,
   input  logic             word_ready,
   input  logic [10:0]      word,
   input  logic             pkt_ready,
   output logic             pkt_valid,
   output logic [2:0]       buttons,
   output logic [8:0]       dx,
   output logic [8:0]       dy,
   output logic             ovf_x,
   output logic             ovf_y,
   output logic [32:0]      raw_pkt,
   output logic             frame_err,
   output logic             rdr_clr,
   output logic [ERR_W-1:0] err_count,
   output logic             busy
);

   localparam int            TW       = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_B0   = 2'd0,
      S_B1   = 2'd1,
      S_B2   = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t          state_reg;
   logic            word_ready_reg;
   logic [TW-1:0]   tmo_cnt_reg;
   logic [10:0]     frame0_reg;
   logic [10:0]     frame1_reg;

   logic [7:0]      cur_byte;
   logic [7:0]      byte1;
   logic            frame_edge;
   logic            frame_ok;
   logic            frame_sync;
   logic            tmo_hit;
   logic            err_fire;
   logic            tmo_fire;

   // Data bits arrive LSB first: D0 sits in word[9], so byte bit i is frame bit 9-i.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_bit_rev
         assign cur_byte[gi] = word[9-gi];
         assign byte1[gi]    = frame1_reg[9-gi];
      end
   endgenerate

   assign frame_edge = word_ready & ~word_ready_reg;
   assign frame_ok   = ~word[10] & word[0] & (~CHECK_PARITY | (^word[9:1]));
   assign frame_sync = frame_ok & cur_byte[3];
   assign tmo_hit    = (tmo_cnt_reg == TMO_LAST);

   // Classify this cycle's error events so the counter and the pulses agree exactly.
   always_comb begin
      err_fire = 1'b0;
      tmo_fire = 1'b0;
      case (state_reg)
         S_B0: begin
            if (frame_edge && !frame_sync) err_fire = 1'b1;
         end
         S_B1, S_B2: begin
            if (frame_edge) begin
               if (!frame_ok) err_fire = 1'b1;
            end else if (tmo_hit) begin
               err_fire = 1'b1;
               tmo_fire = 1'b1;
            end
         end
         S_HOLD: begin
            if (frame_edge) begin
               if (pkt_ready) err_fire = !frame_sync;
               else           err_fire = 1'b1;
            end
         end
         default: begin
            err_fire = 1'b0;
            tmo_fire = 1'b0;
         end
      endcase
   end

   always_ff @(posedge ck or negedge reset) begin
      if (!reset) begin
         state_reg      <= S_B0;
         word_ready_reg <= 1'b0;
         tmo_cnt_reg    <= '0;
         frame0_reg     <= '0;
         frame1_reg     <= '0;
         pkt_valid      <= 1'b0;
         buttons        <= '0;
         dx             <= '0;
         dy             <= '0;
         ovf_x          <= 1'b0;
         ovf_y          <= 1'b0;
         raw_pkt        <= '0;
         frame_err      <= 1'b0;
         rdr_clr        <= 1'b0;
         err_count      <= '0;
         busy           <= 1'b0;
      end else begin
         word_ready_reg <= word_ready;
         frame_err      <= err_fire;
         rdr_clr        <= tmo_fire;
         if (err_fire && (err_count != {ERR_W{1'b1}})) begin
            err_count <= err_count + 1'b1;
         end

         case (state_reg)
            S_B0: begin
               if (frame_edge && frame_sync) begin
                  frame0_reg  <= word;
                  tmo_cnt_reg <= '0;
                  busy        <= 1'b1;
                  state_reg   <= S_B1;
               end
            end

            S_B1: begin
               if (frame_edge) begin
                  tmo_cnt_reg <= '0;
                  if (frame_ok) begin
                     frame1_reg <= word;
                     state_reg  <= S_B2;
                  end else begin
                     busy      <= 1'b0;
                     state_reg <= S_B0;
                  end
               end else if (tmo_fire) begin
                  tmo_cnt_reg <= '0;
                  busy        <= 1'b0;
                  state_reg   <= S_B0;
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
               end
            end

            S_B2: begin
               if (frame_edge) begin
                  tmo_cnt_reg <= '0;
                  busy        <= 1'b0;
                  if (frame_ok) begin
                     // byte0 bit i lives at frame0_reg[9-i]
                     buttons   <= {frame0_reg[7], frame0_reg[8], frame0_reg[9]};
                     dx        <= {frame0_reg[5], byte1};
                     dy        <= {frame0_reg[4], cur_byte};
                     ovf_x     <= frame0_reg[3];
                     ovf_y     <= frame0_reg[2];
                     raw_pkt   <= {frame0_reg, frame1_reg, word};
                     pkt_valid <= 1'b1;
                     state_reg <= S_HOLD;
                  end else begin
                     state_reg <= S_B0;
                  end
               end else if (tmo_fire) begin
                  tmo_cnt_reg <= '0;
                  busy        <= 1'b0;
                  state_reg   <= S_B0;
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
               end
            end

            S_HOLD: begin
               // Retiring the packet frees the sequencer for a frame arriving on the same cycle.
               if (pkt_ready) begin
                  pkt_valid <= 1'b0;
                  state_reg <= S_B0;
                  if (frame_edge && frame_sync) begin
                     frame0_reg  <= word;
                     tmo_cnt_reg <= '0;
                     busy        <= 1'b1;
                     state_reg   <= S_B1;
                  end
               end
            end

            default: begin
               state_reg <= S_B0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mouse_packet_ctrl.sv
// Randomised and directed bench for mouse_packet_ctrl; two instances (parity checked / ignored)
// are compared every cycle against a queue-style packet model.
module tb_mouse_packet_ctrl;

   localparam int T = 40;

   logic        ck = 1'b0;
   logic        reset = 1'b0;
   logic        word_ready = 1'b0;
   logic [10:0] word = '0;
   logic        pkt_ready = 1'b0;

   logic        p_pv, p_ferr, p_rclr, p_busy, p_ox, p_oy;
   logic [2:0]  p_btn;
   logic [8:0]  p_dx, p_dy;
   logic [32:0] p_raw;
   logic [7:0]  p_ecnt;
   logic        n_pv, n_ferr, n_rclr, n_busy, n_ox, n_oy;
   logic [2:0]  n_btn;
   logic [8:0]  n_dx, n_dy;
   logic [32:0] n_raw;
   logic [7:0]  n_ecnt;

   mouse_packet_ctrl #(.TIMEOUT_CYCLES(T), .CHECK_PARITY(1'b1), .ERR_W(8)) dut (
      .ck(ck), .reset(reset), .word_ready(word_ready), .word(word), .pkt_ready(pkt_ready),
      .pkt_valid(p_pv), .buttons(p_btn), .dx(p_dx), .dy(p_dy), .ovf_x(p_ox), .ovf_y(p_oy),
      .raw_pkt(p_raw), .frame_err(p_ferr), .rdr_clr(p_rclr), .err_count(p_ecnt), .busy(p_busy)
   );

   mouse_packet_ctrl #(.TIMEOUT_CYCLES(T), .CHECK_PARITY(1'b0), .ERR_W(8)) dut_np (
      .ck(ck), .reset(reset), .word_ready(word_ready), .word(word), .pkt_ready(pkt_ready),
      .pkt_valid(n_pv), .buttons(n_btn), .dx(n_dx), .dy(n_dy), .ovf_x(n_ox), .ovf_y(n_oy),
      .raw_pkt(n_raw), .frame_err(n_ferr), .rdr_clr(n_rclr), .err_count(n_ecnt), .busy(n_busy)
   );

   always #5 ck = ~ck;

   int n_checks = 0;
   int n_fail   = 0;
   int pv_seen, ferr_seen, rclr_seen;

   // Model state, index 0 = parity checked, 1 = parity ignored.
   logic [10:0] m_fr [2][3];
   int          m_n      [2];
   int          m_silent [2];
   int          m_ecnt   [2];
   logic        m_prev   [2];
   logic        m_hold   [2];
   logic        m_pv     [2];
   logic        m_ferr   [2];
   logic        m_rclr   [2];
   logic        m_busy   [2];
   logic        m_ox     [2];
   logic        m_oy     [2];
   logic [2:0]  m_btn    [2];
   logic [8:0]  m_dx     [2];
   logic [8:0]  m_dy     [2];
   logic [32:0] m_raw    [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] frame_byte(input logic [10:0] f);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[i] = f[9-i];
      return b;
   endfunction

   function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
      logic [10:0] f;
      f[10] = 1'b0;
      for (int i = 0; i < 8; i++) f[9-i] = b[i];
      f[1] = ~(^b) ^ bad_par;
      f[0] = 1'b1;
      return f;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_n[k] = 0; m_silent[k] = 0; m_ecnt[k] = 0; m_prev[k] = 1'b0; m_hold[k] = 1'b0;
         m_pv[k] = 1'b0; m_ferr[k] = 1'b0; m_rclr[k] = 1'b0; m_busy[k] = 1'b0;
         m_ox[k] = 1'b0; m_oy[k] = 1'b0; m_btn[k] = '0; m_dx[k] = '0; m_dy[k] = '0;
         m_raw[k] = '0;
      end
   endtask

   task automatic take_frame(input int k, input logic [10:0] w);
      logic       ok;
      logic [7:0] b0, b1, b2;
      ok = !w[10] && w[0] && ((k == 1) || (^w[9:1]));
      if (!ok || (m_n[k] == 0 && !frame_byte(w)[3])) begin
         m_ferr[k] = 1'b1;
         m_n[k]    = 0;
      end else begin
         m_fr[k][m_n[k]] = w;
         m_n[k]++;
         m_silent[k] = 0;
         if (m_n[k] == 3) begin
            b0 = frame_byte(m_fr[k][0]);
            b1 = frame_byte(m_fr[k][1]);
            b2 = frame_byte(m_fr[k][2]);
            m_btn[k] = b0[2:0];
            m_dx[k]  = {b0[4], b1};
            m_dy[k]  = {b0[5], b2};
            m_ox[k]  = b0[6];
            m_oy[k]  = b0[7];
            m_raw[k] = {m_fr[k][0], m_fr[k][1], m_fr[k][2]};
            m_pv[k]  = 1'b1;
            m_hold[k] = 1'b1;
            m_n[k]   = 0;
         end
      end
   endtask

   task automatic model_step(input int k, input logic wr, input logic [10:0] w, input logic rdy);
      logic e;
      e = wr && !m_prev[k];
      m_prev[k] = wr;
      m_ferr[k] = 1'b0;
      m_rclr[k] = 1'b0;
      if (m_hold[k]) begin
         if (rdy) begin
            m_hold[k] = 1'b0;
            m_pv[k]   = 1'b0;
            if (e) take_frame(k, w);
         end else if (e) begin
            m_ferr[k] = 1'b1;
         end
      end else if (e) begin
         take_frame(k, w);
      end else if (m_n[k] > 0) begin
         m_silent[k]++;
         if (m_silent[k] == T) begin
            m_ferr[k] = 1'b1;
            m_rclr[k] = 1'b1;
            m_n[k]    = 0;
         end
      end
      if (m_ferr[k] && m_ecnt[k] < 255) m_ecnt[k]++;
      m_busy[k] = (m_n[k] > 0);
   endtask

   task automatic compare_all();
      chk("p.pkt_valid", 64'(p_pv),   64'(m_pv[0]));
      chk("p.buttons",   64'(p_btn),  64'(m_btn[0]));
      chk("p.dx",        64'(p_dx),   64'(m_dx[0]));
      chk("p.dy",        64'(p_dy),   64'(m_dy[0]));
      chk("p.ovf",       64'({p_ox, p_oy}), 64'({m_ox[0], m_oy[0]}));
      chk("p.raw_pkt",   64'(p_raw),  64'(m_raw[0]));
      chk("p.frame_err", 64'(p_ferr), 64'(m_ferr[0]));
      chk("p.rdr_clr",   64'(p_rclr), 64'(m_rclr[0]));
      chk("p.err_count", 64'(p_ecnt), 64'(m_ecnt[0]));
      chk("p.busy",      64'(p_busy), 64'(m_busy[0]));
      chk("n.pkt_valid", 64'(n_pv),   64'(m_pv[1]));
      chk("n.decode",    64'({n_btn, n_dx, n_dy, n_ox, n_oy}),
                         64'({m_btn[1], m_dx[1], m_dy[1], m_ox[1], m_oy[1]}));
      chk("n.raw_pkt",   64'(n_raw),  64'(m_raw[1]));
      chk("n.pulses",    64'({n_ferr, n_rclr}), 64'({m_ferr[1], m_rclr[1]}));
      chk("n.err_count", 64'(n_ecnt), 64'(m_ecnt[1]));
      chk("n.busy",      64'(n_busy), 64'(m_busy[1]));
      if (p_pv)   pv_seen++;
      if (p_ferr) ferr_seen++;
      if (p_rclr) rclr_seen++;
   endtask

   task automatic tick(input logic wr, input logic [10:0] w, input logic rdy);
      word_ready = wr;
      word       = w;
      pkt_ready  = rdy;
      model_step(0, wr, w, rdy);
      model_step(1, wr, w, rdy);
      @(negedge ck);
      compare_all();
   endtask

   // rdy_mode: 0/1 constant pkt_ready, 2 random per cycle
   task automatic send(input logic [10:0] w, input int gap, input int rdy_mode);
      tick(1'b1, w, (rdy_mode == 2) ? ($urandom_range(0, 9) < 7) : rdy_mode[0]);
      for (int i = 0; i < gap; i++)
         tick(1'b0, w, (rdy_mode == 2) ? ($urandom_range(0, 9) < 7) : rdy_mode[0]);
   endtask

   task automatic clear_seen();
      pv_seen = 0; ferr_seen = 0; rclr_seen = 0;
   endtask

   initial begin
      logic [10:0] f;
      logic [7:0]  b;
      int          r;
      int          gap;

      model_reset();
      repeat (3) @(negedge ck);
      chk("reset.outputs", 64'({p_pv, p_btn, p_dx, p_dy, p_ox, p_oy, p_ferr, p_rclr, p_busy}), 64'd0);
      chk("reset.raw_ecnt", 64'({p_raw, p_ecnt}), 64'd0);
      reset = 1'b1;
      @(negedge ck);
      compare_all();

      // Basic packet, consumer always ready
      clear_seen();
      send(mk_frame(8'h29, 1'b0), 2, 1);
      send(mk_frame(8'h05, 1'b0), 2, 1);
      send(mk_frame(8'hFE, 1'b0), 3, 1);
      chk("t1.pv_pulses", 64'(pv_seen), 64'd1);
      chk("t1.decode", 64'({p_btn, p_dx, p_dy, p_ox, p_oy}), 64'({3'b001, 9'h005, 9'h1FE, 2'b00}));
      chk("t1.err_count", 64'(p_ecnt), 64'd0);

      // Non-sync first frame is dropped
      send(mk_frame(8'h05, 1'b0), 2, 1);
      send(mk_frame(8'h08, 1'b0), 2, 1);
      send(mk_frame(8'h10, 1'b0), 2, 1);
      send(mk_frame(8'h20, 1'b0), 3, 1);
      chk("t2.err_count", 64'(p_ecnt), 64'd1);
      chk("t2.decode", 64'({p_btn, p_dx, p_dy}), 64'({3'b000, 9'h010, 9'h020}));

      // Bad parity in byte1 position
      send(mk_frame(8'h09, 1'b0), 2, 1);
      send(mk_frame(8'h33, 1'b1), 2, 1);
      chk("t3.busy_par", 64'(p_busy), 64'd0);
      chk("t3.busy_nopar", 64'(n_busy), 64'd1);
      send(mk_frame(8'h19, 1'b0), 2, 1);
      send(mk_frame(8'h7F, 1'b0), 2, 1);
      send(mk_frame(8'h80, 1'b0), T + 5, 1);
      chk("t3.decode", 64'({p_btn, p_dx, p_dy}), 64'({3'b001, 9'h17F, 9'h080}));
      chk("t3.err_count", 64'(p_ecnt), 64'd2);

      // Timeout after two frames
      clear_seen();
      send(mk_frame(8'h08, 1'b0), 2, 1);
      send(mk_frame(8'h01, 1'b0), T + 10, 1);
      chk("t4.rdr_clr", 64'(rclr_seen), 64'd1);
      chk("t4.frame_err", 64'(ferr_seen), 64'd1);
      chk("t4.busy", 64'(p_busy), 64'd0);
      chk("t4.no_pkt", 64'(pv_seen), 64'd0);

      // Frame landing on the expiry cycle wins
      clear_seen();
      send(mk_frame(8'h08, 1'b0), T - 1, 1);
      send(mk_frame(8'h01, 1'b0), 2, 1);
      chk("t4b.no_tmo", 64'(rclr_seen), 64'd0);
      chk("t4b.busy", 64'(p_busy), 64'd1);
      send(mk_frame(8'h02, 1'b0), 2, 1);
      chk("t4b.pkt", 64'(pv_seen), 64'd1);
      // One cycle later the timeout has already fired
      clear_seen();
      send(mk_frame(8'h08, 1'b0), T, 1);
      send(mk_frame(8'h01, 1'b0), 2, 1);
      chk("t4c.tmo", 64'(rclr_seen), 64'd1);
      chk("t4c.frame_err", 64'(ferr_seen), 64'd2);

      // Held packet, overrun, then retire-and-start on the same edge
      send(mk_frame(8'h09, 1'b0), 2, 0);
      send(mk_frame(8'h01, 1'b0), 2, 0);
      send(mk_frame(8'h02, 1'b0), 3, 0);
      clear_seen();
      send(mk_frame(8'h0A, 1'b0), 3, 0);
      chk("t5.overrun", 64'(ferr_seen), 64'd1);
      chk("t5.held", 64'({p_pv, p_dx, p_dy}), 64'({1'b1, 9'h001, 9'h002}));
      send(mk_frame(8'h0C, 1'b0), 2, 1);
      send(mk_frame(8'h03, 1'b0), 2, 1);
      send(mk_frame(8'h04, 1'b0), 3, 1);
      chk("t5.new_pkt", 64'({p_btn, p_dx, p_dy}), 64'({3'b100, 9'h003, 9'h004}));

      // Randomised traffic
      for (int i = 0; i < 500; i++) begin
         b = 8'($urandom);
         if ($urandom_range(0, 1) == 0) b[3] = 1'b1;
         f = mk_frame(b, 1'b0);
         r = $urandom_range(0, 99);
         if (r < 6)       f[1]  = ~f[1];
         else if (r < 9)  f[10] = 1'b1;
         else if (r < 12) f[0]  = 1'b0;
         gap = ($urandom_range(0, 99) < 3) ? (T - 2 + $urandom_range(0, 3)) : $urandom_range(1, 4);
         send(f, gap, 2);
      end

      // Saturate the error counter
      for (int i = 0; i < 300; i++) send(11'h7FF, 1, 1);
      chk("t6.err_sat", 64'(p_ecnt), 64'd255);

      // Reset asserted while in the middle of a packet
      send(mk_frame(8'h08, 1'b0), 2, 1);
      send(mk_frame(8'h01, 1'b0), 2, 1);
      chk("t6.busy_before", 64'(p_busy), 64'd1);
      reset = 1'b0;
      #1;
      chk("t6.reset_outputs", 64'({p_pv, p_btn, p_dx, p_dy, p_ox, p_oy, p_ferr, p_rclr, p_busy}), 64'd0);
      chk("t6.reset_raw_ecnt", 64'({p_raw, p_ecnt}), 64'd0);
      @(negedge ck);
      reset = 1'b1;
      model_reset();
      send(mk_frame(8'h29, 1'b0), 2, 1);
      send(mk_frame(8'h05, 1'b0), 2, 1);
      send(mk_frame(8'hFE, 1'b0), 3, 1);
      chk("t6.after_reset", 64'({p_dx, p_dy, p_ecnt}), 64'({9'h005, 9'h1FE, 8'd0}));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
